// File: rtl/msg_fifo.sv
// msg_fifo: clocked, parametrised first-word-fall-through message queue used
// to pass fixed-width messages between game-logic units (for example
// cell-reveal requests travelling to the board updater).
//
// Optional feature macro: MSG_FIFO_STATS_EN
//   When defined, adds the high_water output: the largest occupancy seen since
//   the last reset. Flush leaves it untouched.
//
// Ports:
//   clock         single system clock, rising edge active
//   reset         synchronous active-high reset (highest priority)
//   flush         synchronous clear of queue contents (below reset)
//   wr_data       message offered by the producer
//   wr_valid      producer offers wr_data; must hold until accepted
//   wr_ready      queue can accept a message (not full)
//   rd_data       head message, meaningful while rd_valid is high
//   rd_valid      queue holds at least one message
//   rd_ready      consumer takes the head message
//   count         current occupancy, 0..2**depth_log2
//   almost_full   count >= afull_level
//   almost_empty  count <= aempty_level
//   high_water    (MSG_FIFO_STATS_EN only) peak occupancy since reset
module msg_fifo #(
  parameter int msg_width    = 8,
  parameter int depth_log2   = 3,
  parameter int afull_level  = 6,
  parameter int aempty_level = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [msg_width-1:0] wr_data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  output logic [msg_width-1:0] rd_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [depth_log2:0]  count,
  output logic                 almost_full,
  output logic                 almost_empty
`ifdef MSG_FIFO_STATS_EN
  ,
  output logic [depth_log2:0]  high_water
`endif
);

  localparam int depth = 1 << depth_log2;
  localparam logic [depth_log2:0] full_count = depth[depth_log2:0];

  logic [msg_width-1:0]  mem [depth];
  logic [depth_log2-1:0] wr_ptr;
  logic [depth_log2-1:0] rd_ptr;
  logic                  push;
  logic                  pop;

  // All status outputs come from the registered count, so neither wr_valid
  // nor rd_ready has a combinational path to any output. Because wr_ready is
  // low when full, a pop in the same cycle cannot make room for a push.
  assign wr_ready     = (count != full_count);
  assign rd_valid     = (count != '0);
  assign almost_full  = (int'(count) >= afull_level);
  assign almost_empty = (int'(count) <= aempty_level);

  assign push = wr_valid && wr_ready;
  assign pop  = rd_valid && rd_ready;

  // Head of queue falls straight through; when empty this simply shows
  // whatever the storage slot under rd_ptr last held.
  assign rd_data = mem[rd_ptr];

  // Storage has no reset; writes are suppressed during reset and flush so a
  // discarded push never lands in the array.
  always_ff @(posedge clock) begin
    if (push && !reset && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at depth; count tracks occupancy directly so
  // full and empty are unambiguous when the pointers are equal.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef MSG_FIFO_STATS_EN
  // Peak occupancy lags count by one cycle; only reset clears it.
  always_ff @(posedge clock) begin
    if (reset) begin
      high_water <= '0;
    end else if (count > high_water) begin
      high_water <= count;
    end
  end
`endif

endmodule

// File: tb/tb_msg_fifo.sv
// tb_msg_fifo: directed bench for msg_fifo with default parameters
// (8-bit messages, depth 8, almost_full at 6, almost_empty at 1).
// Accepted pushes are queued as expected messages; an independent monitor
// pops and compares whenever the queue presents a message that is taken.
module tb_msg_fifo;

  logic       clock;
  logic       reset;
  logic       flush;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [3:0] count;
  logic       almost_full;
  logic       almost_empty;
`ifdef MSG_FIFO_STATS_EN
  logic [3:0] high_water;
`endif

  int checks = 0;
  int errors = 0;
  int model_count = 0;
  logic [7:0] exp_q [$];

  // Hand-computed occupancy while draining from full with the held 0x99
  // accepted on the second cycle.
  int drain_counts [8] = '{7, 7, 6, 5, 4, 3, 2, 1};

  msg_fifo dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`ifdef MSG_FIFO_STATS_EN
    ,
    .high_water   (high_water)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected-message side: a push offered while the queue is not full will be
  // taken at the coming edge, so its data joins the expected queue.
  always @(negedge clock) begin
    bit push_ok;
    bit pop_ok;
    if (reset || flush) begin
      exp_q.delete();
      model_count = 0;
    end else begin
      push_ok = wr_valid && (model_count < 8);
      pop_ok  = rd_ready && (model_count > 0);
      if (push_ok) begin
        exp_q.push_back(wr_data);
      end
      model_count = model_count + int'(push_ok) - int'(pop_ok);
    end
  end

  // Monitor: whenever a head message is being taken, it must match the oldest
  // expected message.
  always @(negedge clock) begin
    logic [7:0] exp_msg;
    if (!reset && !flush && rd_valid === 1'b1 && rd_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL rd_data: got %02h, expected no message", rd_data);
      end else begin
        exp_msg = exp_q.pop_front();
        if (rd_data !== exp_msg) begin
          errors++;
          $display("[TB] FAIL rd_data: got %02h, expected %02h", rd_data, exp_msg);
        end
      end
    end
  end

  task automatic cmp(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then return just after the edge that used them.
  task automatic applyStimulus(input logic wv, input logic [7:0] wd, input logic rr,
                               input logic fl, input logic rs);
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    flush    = fl;
    reset    = rs;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input int exp_count);
    cmp({name, ".count"},        32'(count),        32'(exp_count));
    cmp({name, ".wr_ready"},     32'(wr_ready),     (exp_count != 8) ? 32'd1 : 32'd0);
    cmp({name, ".rd_valid"},     32'(rd_valid),     (exp_count != 0) ? 32'd1 : 32'd0);
    cmp({name, ".almost_full"},  32'(almost_full),  (exp_count >= 6) ? 32'd1 : 32'd0);
    cmp({name, ".almost_empty"}, 32'(almost_empty), (exp_count <= 1) ? 32'd1 : 32'd0);
  endtask

  task automatic checkDrained(input string name);
    cmp({name, ".pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no end of test, expected finish before 100000");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset    = 1'b1;
    flush    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    rd_ready = 1'b0;
    @(posedge clock);
    #1;

    // Reset, then idle
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("reset", 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("idle", 0);

    // Fill with 0x11..0x88
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 8'(8'h11 * i), 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("fill%0d", i), i);
    end

    // Ninth push is held off while full
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("hold%0d", i), 8);
    end

    // Drain from full; 0x99 gets in after the first pop
    for (int i = 0; i < 8; i++) begin
      applyStimulus((i < 2) ? 1'b1 : 1'b0, 8'h99, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("drain%0d", i), drain_counts[i]);
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("drain_last", 0);
    checkDrained("drain_sb");

    // Hold occupancy at 3 with simultaneous push and pop across wrap
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("pre%0d", i), i);
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 8'(8'hB0 + i), 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("steady%0d", i), 3);
    end
    for (int i = 2; i >= 0; i--) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("tail%0d", i), i);
    end
    checkDrained("steady_sb");

    // Flush at occupancy 5 with a push offered
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("pref%0d", i), i);
    end
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
    checkOutput("flush", 0);
`ifdef MSG_FIFO_STATS_EN
    cmp("flush.high_water", 32'(high_water), 32'd8);
`endif
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    checkOutput("post_flush_push", 1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("post_flush_pop", 0);
    checkDrained("flush_sb");

    // Reset mid-stream at occupancy 4 with push and pop pending
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("prer%0d", i), i);
    end
    applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
    checkOutput("mid_reset", 0);
`ifdef MSG_FIFO_STATS_EN
    cmp("mid_reset.high_water", 32'(high_water), 32'd0);
`endif
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    checkOutput("post_reset_push", 1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("post_reset_pop", 0);
`ifdef MSG_FIFO_STATS_EN
    cmp("post_reset.high_water", 32'(high_water), 32'd1);
`endif
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkDrained("reset_sb");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/msg_fifo.md
Name: msg_fifo

Overview:
- Clocked, parametrised message queue for passing fixed-width messages between game-logic units (e.g. cell-reveal requests to the board updater).
- Successor to the unclocked edge-triggered queue. Adds a single clock domain, synchronous reset, a valid/ready handshake on both sides, configurable width and depth, an occupancy count, almost-full/almost-empty flags and a flush.
- First-word-fall-through: the head message is presented on rd_data whenever rd_valid is high.

Parameters:
- msg_width, 8, bits per message.
- depth_log2, 3, log2 of the queue depth; depth = 2^depth_log2, minimum depth_log2 = 1.
- afull_level, 6, almost_full asserts when count >= afull_level.
- aempty_level, 1, almost_empty asserts when count <= aempty_level.

Ports:
- clock  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of queue contents; lower priority than reset.
- wr_data  input  msg_width  message to enqueue.
- wr_valid  input  1  producer offers wr_data.
- wr_ready  output  1  queue can accept; equals !full.
- rd_data  output  msg_width  head message; valid only while rd_valid = 1.
- rd_valid  output  1  queue non-empty; equals !empty.
- rd_ready  input  1  consumer takes the head.
- count  output  depth_log2+1  current occupancy, 0..depth.
- almost_full  output  1  count >= afull_level.
- almost_empty  output  1  count <= aempty_level.

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Storage:
  - depth x msg_width register array.
  - wr_ptr and rd_ptr are depth_log2 bits each and wrap naturally from depth-1 to 0.
  - count register is depth_log2+1 bits.
- Push: occurs on a clock edge when wr_valid && wr_ready.
  - Writes wr_data to mem[wr_ptr] and increments wr_ptr.
- Pop: occurs on a clock edge when rd_valid && rd_ready.
  - Increments rd_ptr.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
- Latency:
  - A message pushed at edge N appears on rd_data with rd_valid = 1 after edge N (one cycle).
  - rd_data is a combinational read of mem[rd_ptr]. No extra read latency.
- Full (count = depth):
  - wr_ready = 0. A push is not accepted even if a pop occurs in the same cycle.
  - wr_ready rises the cycle after the pop.
- Empty (count = 0):
  - rd_valid = 0 and rd_ready is ignored.
  - rd_data is don't-care but must not be X-propagating; it holds the last mem[rd_ptr] value.
  - No write-to-read bypass in the same cycle.
- Producer rule: wr_valid/wr_data must be held until accepted. The queue never drops or duplicates a message.
- Flags:
  - wr_ready, rd_valid, almost_full and almost_empty are decoded from registered count only.
  - No combinational path from wr_valid or rd_ready to any output.
- Reset (any cycle, including mid-stream):
  - wr_ptr = rd_ptr = count = 0, so wr_ready = 1, rd_valid = 0, almost_full = 0, almost_empty = 1.
  - Memory contents are not cleared.
  - Pushes or pops presented in the reset cycle are discarded.
- Flush (reset low): same pointer/count clear as reset. A push or pop in the same cycle is discarded.
- Priority: reset > flush > push/pop.

Optional Feature:
- Macro: MSG_FIFO_STATS_EN.
- When defined:
  - Adds output high_water (depth_log2+1 bits): the maximum count seen since the last reset.
  - Updated on the cycle after count exceeds the stored value.
  - Cleared to 0 on reset only; retained across flush.
- When undefined: port and register are absent. All other behaviour is identical.

Test Plan (defaults: msg_width = 8, depth = 8):
- Reset then idle -> count = 0, wr_ready = 1, rd_valid = 0, almost_empty = 1, almost_full = 0.
- Push 0x11..0x88 back-to-back with rd_ready = 0:
  - count 1..8, one per cycle.
  - almost_full rises at count = 6.
  - wr_ready = 0 at count = 8.
  - A 9th push of 0x99 is held and not accepted.
- From full, rd_ready = 1 for 8 cycles:
  - rd_data sequence 0x11,0x22,...,0x88.
  - The held 0x99 is accepted the cycle after the first pop.
  - Ordering and wrap-around are preserved.
- Count 3, simultaneous push and pop for 10 cycles -> count stays 3, output order strictly FIFO across pointer wrap.
- Count 5, assert flush with wr_valid = 1 -> next cycle count = 0, rd_valid = 0, pushed message absent. With MSG_FIFO_STATS_EN, high_water still = 5 (or the prior maximum).
- Reset asserted mid-stream at count 4 with a push and pop pending -> next cycle count = 0, wr_ready = 1, rd_valid = 0. A subsequent push of 0xA5 reads back 0xA5.
